// File: rtl/ingress_port_buffer.sv
// rtl/ingress_port_buffer.sv - per-port ingress packet store feeding the Scheduler
// Linear-write RAM buffer with a published write pointer, 1-cycle read port and a saturating drop counter.
module ingress_port_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_add,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_add,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic [CNT_W-1:0]  drop_count
);

  typedef enum logic {ST_RUN, ST_FULL} state_t;

  // The top address is sacrificed so wr_add can park there without wrapping.
  localparam logic [ADDR_W-1:0] LAST_WR = {{(ADDR_W-1){1'b1}}, 1'b0};

  state_t            state;
  logic              wr_fire;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  assign wr_fire = in_valid && (state == ST_RUN) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      wr_add     <= '0;
      in_ready   <= 1'b1;
      full       <= 1'b0;
      drop_count <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (in_valid) begin
            wr_add <= wr_add + ADDR_W'(1);
            if (wr_add == LAST_WR) begin
              state    <= ST_FULL;
              in_ready <= 1'b0;
              full     <= 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (in_valid && (drop_count != {CNT_W{1'b1}}))
            drop_count <= drop_count + CNT_W'(1);
        end
        default: state <= ST_FULL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wr_add] <= in_data;
  end

  // Non-blocking read of mem gives read-first behaviour on a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_data <= '0;
    else if (rd_en)
      rd_data <= mem[rd_add];
  end

endmodule

// File: tb/tb_ingress_port_buffer.sv
// tb/tb_ingress_port_buffer.sv - directed bench for ingress_port_buffer
// Small-geometry instance (ADDR_W=4, CNT_W=2) with a read scoreboard and a reference memory model.
module tb_ingress_port_buffer;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_add = '0;
  logic          in_ready;
  logic          full;
  logic [AW-1:0] wr_add;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] drop_count;

  always #5 clk = ~clk;

  ingress_port_buffer #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_add(wr_add), .rd_en(rd_en), .rd_add(rd_add),
    .rd_data(rd_data), .full(full), .drop_count(drop_count)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  int m_wr = 0;
  bit m_full = 1'b0;
  int m_drop = 0;
  logic [DW-1:0] exp_q [$];
  int sat_exp [5] = '{1, 2, 3, 3, 3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Predict the coming edge from current inputs, clock it, then compare 1ns later.
  task automatic cycle();
    bit was_reset;
    was_reset = reset;
    if (reset) begin
      m_wr = 0; m_full = 1'b0; m_drop = 0;
      exp_q.delete();
    end else begin
      if (rd_en) exp_q.push_back(m_mem[rd_add]);
      if (in_valid && !m_full) begin
        m_mem[m_wr] = in_data;
        if (m_wr == (1<<AW)-2) m_full = 1'b1;
        m_wr++;
      end else if (in_valid && m_full && m_drop < (1<<CW)-1) begin
        m_drop++;
      end
    end
    @(posedge clk);
    #1;
    if (was_reset) check("rd_data_rst", rd_data, 32'h0);
    else if (exp_q.size() > 0) check("rd_data_sb", rd_data, exp_q.pop_front());
    check("wr_add", 32'(wr_add), 32'(m_wr));
    check("full", 32'(full), 32'(m_full));
    check("in_ready", 32'(in_ready), 32'(!m_full));
    check("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  task automatic wr(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    cycle();
  endtask

  initial begin
    cycle();
    cycle();
    reset = 1'b0;
    check("rst_wr_add", 32'(wr_add), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_rd_data", rd_data, 32'h0);

    // basic write then read-back
    wr(32'h1); wr(32'h2); wr(32'h3);
    in_valid = 1'b0; rd_en = 1'b1; rd_add = 4'd1;
    cycle();
    check("t2_wr_add", 32'(wr_add), 32'h3);
    check("t2_rd", rd_data, 32'h2);
    rd_en = 1'b0;
    wr(32'h4); wr(32'h5); wr(32'hAAAA_AAAA); wr(32'h6);
    in_valid = 1'b0;
    cycle();
    check("rd_hold", rd_data, 32'h2);

    // async reset in the middle of a burst
    in_valid = 1'b1; in_data = 32'h7;
    cycle();
    #2 reset = 1'b1;
    #1;
    check("t1_wr_add", 32'(wr_add), 32'h0);
    check("t1_in_ready", 32'(in_ready), 32'h1);
    check("t1_full", 32'(full), 32'h0);
    check("t1_drop", 32'(drop_count), 32'h0);
    check("t1_rd_data", rd_data, 32'h0);
    in_data = 32'hDEAD_BEEF;
    cycle();
    reset = 1'b0;

    // refill to address 4, including a zero word, then collide at address 5
    for (int i = 0; i < 5; i++) wr((i == 2) ? 32'h0 : 32'h10 + 32'(i));
    in_data = 32'h5555_5555; rd_en = 1'b1; rd_add = 4'd5;
    cycle();
    check("t5_old", rd_data, 32'hAAAA_AAAA);
    in_valid = 1'b0;
    cycle();
    check("t5_new", rd_data, 32'h5555_5555);
    rd_add = 4'd2;
    cycle();
    check("zero_word", rd_data, 32'h0);
    rd_en = 1'b0;

    // fill the remaining capacity
    for (int i = 6; i < 15; i++) wr(32'h100 + 32'(i));
    check("t3_wr_add", 32'(wr_add), 32'hF);
    check("t3_full", 32'(full), 32'h1);
    check("t3_in_ready", 32'(in_ready), 32'h0);
    check("t3_drop0", 32'(drop_count), 32'h0);

    in_data = 32'h0BAD_0BAD;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_drop", 32'(drop_count), 32'(sat_exp[i]));
      check("t4_wr_add", 32'(wr_add), 32'hF);
    end

    in_valid = 1'b0; rd_en = 1'b1; rd_add = 4'd14;
    cycle();
    check("t3_last_word", rd_data, 32'h10E);
    check("t4_hold", 32'(drop_count), 32'h3);
    rd_en = 1'b0;

    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("exit_full", 32'(full), 32'h0);
    check("exit_in_ready", 32'(in_ready), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
